// File: rtl/cic_rr_arbiter.sv
// Merges several CIC decimator outputs onto one valid/ready stream.
// Per-channel holding registers are drained in round-robin order.
module cic_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DW     = 32,
  parameter int CW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] ch_data,
  input  logic [NUM_CH-1:0]    ch_rdy,
  output logic [DW-1:0]        out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_CH-1:0]    overflow,
  input  logic                 clr_ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]     hold_q [NUM_CH];
  logic [DW-1:0]     hold_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] gnt;
  logic [CW-1:0]     last_q, last_d;
  logic [CW-1:0]     out_ch_q, out_ch_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [CW-1:0]     sel;
  logic [CW:0]       rr_sum;
  logic              found;
  logic              opp;

  assign opp = (state_q == IDLE) || out_ready;

  // Search starts one past the last winner and wraps modulo NUM_CH.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    rr_sum = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_sum = {1'b0, last_q} + (CW+1)'(k);
      if (rr_sum >= (CW+1)'(NUM_CH))
        rr_sum = rr_sum - (CW+1)'(NUM_CH);
      if (!found && pend_q[rr_sum[CW-1:0]]) begin
        found = 1'b1;
        sel   = rr_sum[CW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (opp && found)
      gnt[sel] = 1'b1;
  end

  // A strobe on the granted channel refills it without loss.
  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    ovf_d  = clr_ovf ? '0 : ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i])
        pend_d[i] = 1'b0;
      if (ch_rdy[i]) begin
        hold_d[i] = ch_data[i*DW +: DW];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !gnt[i])
          ovf_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    if (opp) begin
      unique case (found)
        1'b1: begin
          state_d    = SEND;
          last_d     = sel;
          out_data_d = hold_q[sel];
          out_ch_d   = sel;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= CW'(NUM_CH-1);
      pend_q     <= '0;
      ovf_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      for (int i = 0; i < NUM_CH; i++)
        hold_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      for (int i = 0; i < NUM_CH; i++)
        hold_q[i] <= hold_d[i];
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cic_rr_arbiter.sv
// Directed bench for cic_rr_arbiter, 4 channels x 32 bits.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_cic_rr_arbiter;

  logic         clk;
  logic         rst;
  logic [127:0] ch_data;
  logic [3:0]   ch_rdy;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   overflow;
  logic         clr_ovf;

  int vecs;
  int errs;

  cic_rr_arbiter #(
    .NUM_CH(4),
    .DW(32),
    .CW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_data(ch_data),
    .ch_rdy(ch_rdy),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_rdy = '0;
    clr_ovf = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_rdy = 4'hf;
    out_ready = 1'b1;
    ch_data = {4{32'hdead_beef}};
    step();
    vecs++;
    if ({out_valid, out_ch, out_data, overflow} !== 39'd0) begin
      errs++;
      $display("FAIL reset: got v=%b ch=%0d d=%h ovf=%b want all zero",
               out_valid, out_ch, out_data, overflow);
    end
    rst = 1'b0;
    ch_rdy = '0;
    step();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_discard: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    ch_data = '0;
    ch_data[2*32 +: 32] = 32'h0000_1234;
    ch_rdy = 4'b0100;
    step();
    ch_rdy = '0;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_lat1: got v=%b want 0", out_valid);
    end
    step();
    vecs++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 32'h0000_1234}) begin
      errs++;
      $display("FAIL single_out: got v=%b ch=%0d d=%h want 1/2/00001234",
               out_valid, out_ch, out_data);
    end
    step();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_once: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_burst();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++)
      ch_data[c*32 +: 32] = 32'hA0 + 32'(c);
    ch_rdy = 4'b1111;
    step();
    ch_rdy = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      vecs++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'(c), 32'hA0 + 32'(c)}) begin
        errs++;
        $display("FAIL burst_%0d: got v=%b ch=%0d d=%h want 1/%0d/%h",
                 c, out_valid, out_ch, out_data, c, 32'hA0 + 32'(c));
      end
    end
    step();
    vecs++;
    if ({out_valid, overflow} !== 5'b0_0000) begin
      errs++;
      $display("FAIL burst_end: got v=%b ovf=%b want 0/0000",
               out_valid, overflow);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    ch_data[1*32 +: 32] = 32'h55;
    ch_rdy = 4'b0010;
    step();
    ch_rdy = '0;
    ch_data = '0;
    for (int n = 0; n < 5; n++) begin
      step();
      vecs++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 32'h55}) begin
        errs++;
        $display("FAIL bp_hold_%0d: got v=%b ch=%0d d=%h want 1/1/00000055",
                 n, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    step();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_release: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    ch_data[3*32 +: 32] = 32'h33;
    ch_rdy = 4'b1000;
    step();
    ch_rdy = '0;
    step();
    ch_data[0 +: 32] = 32'h11;
    ch_rdy = 4'b0001;
    step();
    ch_data[0 +: 32] = 32'h22;
    step();
    ch_rdy = '0;
    vecs++;
    if ({overflow, out_valid, out_ch, out_data} !== {4'b0001, 1'b1, 2'd3, 32'h33}) begin
      errs++;
      $display("FAIL ovf_set: got ovf=%b v=%b ch=%0d d=%h want 0001/1/3/00000033",
               overflow, out_valid, out_ch, out_data);
    end
    out_ready = 1'b1;
    step();
    vecs++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 32'h22}) begin
      errs++;
      $display("FAIL ovf_drain: got v=%b ch=%0d d=%h want 1/0/00000022",
               out_valid, out_ch, out_data);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    vecs++;
    if ({overflow, out_valid} !== 5'b0000_0) begin
      errs++;
      $display("FAIL ovf_clr: got ovf=%b v=%b want 0000/0", overflow, out_valid);
    end
  endtask

  task automatic test_clr_set_priority();
    do_reset();
    out_ready = 1'b0;
    ch_rdy = 4'b1000;
    step();
    ch_rdy = 4'b0011;
    step();
    step();
    ch_rdy = 4'b0010;
    step();
    ch_rdy = '0;
    vecs++;
    if (overflow !== 4'b0011) begin
      errs++;
      $display("FAIL clrset_pre: got ovf=%b want 0011", overflow);
    end
    clr_ovf = 1'b1;
    ch_rdy = 4'b0001;
    step();
    clr_ovf = 1'b0;
    ch_rdy = '0;
    vecs++;
    if (overflow !== 4'b0001) begin
      errs++;
      $display("FAIL clrset_win: got ovf=%b want 0001", overflow);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    out_ready = 1'b1;
    ch_data[1*32 +: 32] = 32'h10;
    ch_rdy = 4'b0010;
    step();
    ch_data[1*32 +: 32] = 32'h20;
    step();
    ch_rdy = '0;
    vecs++;
    if ({out_valid, out_ch, out_data, overflow} !== {1'b1, 2'd1, 32'h10, 4'b0000}) begin
      errs++;
      $display("FAIL same_old: got v=%b ch=%0d d=%h ovf=%b want 1/1/00000010/0000",
               out_valid, out_ch, out_data, overflow);
    end
    step();
    vecs++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 32'h20}) begin
      errs++;
      $display("FAIL same_new: got v=%b ch=%0d d=%h want 1/1/00000020",
               out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_fairness();
    logic [31:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      for (int c = 0; c < 4; c++)
        ch_data[c*32 +: 32] = (32'(c) << 8) | 32'(n);
      ch_rdy = 4'b1111;
      step();
      if (n >= 1) begin
        exp_d = (32'((n - 1) % 4) << 8) | 32'(n - 1);
        vecs++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'((n - 1) % 4), exp_d}) begin
          errs++;
          $display("FAIL fair_%0d: got v=%b ch=%0d d=%h want 1/%0d/%h",
                   n, out_valid, out_ch, out_data, (n - 1) % 4, exp_d);
        end
      end
    end
    ch_rdy = '0;
    vecs++;
    if (overflow !== 4'b1111) begin
      errs++;
      $display("FAIL fair_ovf: got ovf=%b want 1111", overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    ch_rdy = 4'b1000;
    step();
    ch_rdy = 4'b0111;
    step();
    ch_rdy = 4'b0010;
    step();
    rst = 1'b1;
    ch_rdy = 4'b1111;
    out_ready = 1'b1;
    step();
    vecs++;
    if ({out_valid, overflow, out_data} !== 37'd0) begin
      errs++;
      $display("FAIL rmid_rst: got v=%b ovf=%b d=%h want 0/0000/0",
               out_valid, overflow, out_data);
    end
    rst = 1'b0;
    ch_rdy = '0;
    step();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rmid_flush: got v=%b want 0", out_valid);
    end
    ch_data[2*32 +: 32] = 32'hC2;
    ch_data[3*32 +: 32] = 32'hC3;
    ch_rdy = 4'b1100;
    step();
    ch_rdy = '0;
    step();
    vecs++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 32'hC2}) begin
      errs++;
      $display("FAIL rmid_first: got v=%b ch=%0d d=%h want 1/2/000000c2",
               out_valid, out_ch, out_data);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b1;
    ch_data = '0;
    ch_rdy = '0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_clr_set_priority();
    test_same_cycle();
    test_fairness();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
